// File: rtl/act_buf_pkg.sv
// Shared types and helpers for the activation ping-pong buffer.
package act_buf_pkg;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2,
        BANK_READING = 2'd3
    } bank_state_e;

    // Frame length in words: zero or anything beyond the bank size means a whole bank.
    function automatic logic [31:0] clamp_flen(input logic [31:0] cfg, input logic [31:0] depth);
        return ((cfg == 32'd0) || (cfg > depth)) ? depth : cfg;
    endfunction

endpackage

// File: rtl/act_bank_ram.sv
// Simple dual-port bank RAM: one write port, one registered read port that holds when idle.
module act_bank_ram #(
    parameter int DW     = 16,
    parameter int AWIDTH = 13,
    parameter int DEPTH  = 8192
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic [AWIDTH-1:0] waddr_i,
    input  logic [DW-1:0]     wdata_i,
    input  logic              re_i,
    input  logic [AWIDTH-1:0] raddr_i,
    output logic [DW-1:0]     q_o
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] q_q;

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (we_i && (32'(waddr_i) < 32'(DEPTH))) begin
            mem_q[waddr_i[IW-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            q_q <= '0;
        end else if (re_i) begin
            q_q <= mem_q[raddr_i[IW-1:0]];
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/act_pingpong_buffer.sv
// Activation ping-pong buffer: packs the activation stream into two RAM banks and hands
// each completed bank to the PE through a vld/ack offer and a rel pulse.
//
//  state        | meaning
//  BANK_EMPTY   | free, next fill may start here
//  BANK_FILLING | receiving stream beats
//  BANK_FULL    | complete, waiting to be offered/acked
//  BANK_READING | owned by the PE until rel
module act_pingpong_buffer
    import act_buf_pkg::*;
#(
    parameter int ACT_W  = 8,
    parameter int PACK   = 2,
    parameter int AWIDTH = 13,
    parameter int DEPTH  = 8192
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic [ACT_W-1:0]        ActDMA_TDATA,
    input  logic                    ActDMA_TVALID,
    input  logic                    ActDMA_TLAST,
    output logic                    ActDMA_TREADY,
    input  logic [AWIDTH:0]         cfg_frame_words,
    output logic                    sync_vld,
    output logic                    sync_bank,
    output logic [AWIDTH:0]         sync_len,
    input  logic                    sync_ack,
    input  logic [AWIDTH-1:0]       rd_addr,
    input  logic                    rd_ce,
    output logic [ACT_W*PACK-1:0]   rd_q,
    input  logic                    rel
);
    localparam int DW = ACT_W * PACK;
    localparam int LW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [LW-1:0]   LAST_LANE = LW'(PACK - 1);
    localparam logic [LW-1:0]   LANE_ONE  = LW'(1);
    localparam logic [AWIDTH:0] WORD_ONE  = (AWIDTH+1)'(1);

    bank_state_e     st_q [2];
    bank_state_e     st_d [2];
    logic [AWIDTH:0] len_q [2];
    logic [AWIDTH:0] len_d [2];

    logic            wr_bank_q, wr_bank_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic [AWIDTH:0] wcnt_q, wcnt_d;
    logic [AWIDTH:0] flen_q, flen_d;
    logic [DW-1:0]   pack_q, pack_d;
    logic            tready_q, tready_d;
    logic            nxt_q, nxt_d;
    logic            vld_q, vld_d;
    logic            sbank_q, sbank_d;
    logic [AWIDTH:0] slen_q, slen_d;
    logic            rd_bank_q, rd_bank_d;
    logic            rsel_q, rsel_d;

    logic            beat;
    logic            first_beat;
    logic            last_lane;
    logic            wr_en;
    logic            close;
    logic            acc;
    logic            rel_ok;
    logic            reading_nx;
    logic [AWIDTH:0] flen_cfg;
    logic [AWIDTH:0] flen_eff;
    logic [DW-1:0]   wr_word;
    logic [1:0]      bank_re;
    logic [DW-1:0]   bank_q [2];

    assign beat       = ActDMA_TVALID & tready_q;
    assign first_beat = (st_q[wr_bank_q] == BANK_EMPTY);
    assign flen_cfg   = (AWIDTH+1)'(clamp_flen(32'(cfg_frame_words), 32'(DEPTH)));
    assign flen_eff   = first_beat ? flen_cfg : flen_q;
    assign last_lane  = (lane_q == LAST_LANE);
    assign wr_en      = beat & (last_lane | ActDMA_TLAST);
    assign close      = wr_en & (ActDMA_TLAST | (wcnt_q == (flen_eff - WORD_ONE)));
    assign acc        = vld_q & sync_ack;
    assign rel_ok     = rel & (st_q[rd_bank_q] == BANK_READING);

    // Lanes above the current one are zero so a TLAST partial word is clean.
    always_comb begin
        wr_word = '0;
        for (int l = 0; l < PACK; l++) begin
            if (LW'(l) < lane_q) begin
                wr_word[l*ACT_W +: ACT_W] = pack_q[l*ACT_W +: ACT_W];
            end else if (LW'(l) == lane_q) begin
                wr_word[l*ACT_W +: ACT_W] = ActDMA_TDATA;
            end
        end
    end

    always_comb begin
        st_d      = st_q;
        len_d     = len_q;
        wr_bank_d = wr_bank_q;
        lane_d    = lane_q;
        wcnt_d    = wcnt_q;
        flen_d    = flen_q;
        pack_d    = pack_q;
        nxt_d     = nxt_q;
        rd_bank_d = rd_bank_q;

        if (beat) begin
            pack_d = wr_word;
            lane_d = last_lane ? '0 : (lane_q + LANE_ONE);
            if (first_beat) begin
                st_d[wr_bank_q] = BANK_FILLING;
                flen_d          = flen_cfg;
            end
            if (wr_en) begin
                wcnt_d = wcnt_q + WORD_ONE;
            end
        end

        if (close) begin
            st_d[wr_bank_q]  = BANK_FULL;
            len_d[wr_bank_q] = wcnt_q + WORD_ONE;
            wr_bank_d        = ~wr_bank_q;
            lane_d           = '0;
            wcnt_d           = '0;
        end

        // Banks fill in alternation and are handed over in fill order, so a toggling
        // pointer always names the oldest FULL bank.
        if (acc) begin
            st_d[sbank_q] = BANK_READING;
            rd_bank_d     = sbank_q;
            nxt_d         = ~nxt_q;
        end

        if (rel_ok) begin
            st_d[rd_bank_q] = BANK_EMPTY;
        end

        reading_nx = (st_d[0] == BANK_READING) | (st_d[1] == BANK_READING);
        vld_d      = (st_d[nxt_d] == BANK_FULL) & ~reading_nx;
        sbank_d    = vld_d ? nxt_d : sbank_q;
        slen_d     = vld_d ? len_d[nxt_d] : slen_q;
        tready_d   = (st_d[wr_bank_d] == BANK_EMPTY) | (st_d[wr_bank_d] == BANK_FILLING);
        rsel_d     = bank_re[1] ? 1'b1 : (bank_re[0] ? 1'b0 : rsel_q);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            st_q[0]   <= BANK_EMPTY;
            st_q[1]   <= BANK_EMPTY;
            len_q[0]  <= '0;
            len_q[1]  <= '0;
            wr_bank_q <= 1'b0;
            lane_q    <= '0;
            wcnt_q    <= '0;
            flen_q    <= '0;
            pack_q    <= '0;
            tready_q  <= 1'b0;
            nxt_q     <= 1'b0;
            vld_q     <= 1'b0;
            sbank_q   <= 1'b0;
            slen_q    <= '0;
            rd_bank_q <= 1'b0;
            rsel_q    <= 1'b0;
        end else begin
            st_q      <= st_d;
            len_q     <= len_d;
            wr_bank_q <= wr_bank_d;
            lane_q    <= lane_d;
            wcnt_q    <= wcnt_d;
            flen_q    <= flen_d;
            pack_q    <= pack_d;
            tready_q  <= tready_d;
            nxt_q     <= nxt_d;
            vld_q     <= vld_d;
            sbank_q   <= sbank_d;
            slen_q    <= slen_d;
            rd_bank_q <= rd_bank_d;
            rsel_q    <= rsel_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign bank_re[b] = rd_ce & (st_q[b] == BANK_READING);

        act_bank_ram #(
            .DW     (DW),
            .AWIDTH (AWIDTH),
            .DEPTH  (DEPTH)
        ) u_ram (
            .clk_i   (ap_clk),
            .rst_n_i (ap_rst_n),
            .we_i    (wr_en & (wr_bank_q == 1'(b))),
            .waddr_i (wcnt_q[AWIDTH-1:0]),
            .wdata_i (wr_word),
            .re_i    (bank_re[b]),
            .raddr_i (rd_addr),
            .q_o     (bank_q[b])
        );
    end

    assign ActDMA_TREADY = tready_q;
    assign sync_vld      = vld_q;
    assign sync_bank     = sbank_q;
    assign sync_len      = slen_q;
    assign rd_q          = rsel_q ? bank_q[1] : bank_q[0];

endmodule

// File: tb/tb_act_pingpong_buffer.sv
// Directed bench for act_pingpong_buffer with a frame-level reference model checked every cycle.
module tb_act_pingpong_buffer;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic [7:0]  ActDMA_TDATA = '0;
    logic        ActDMA_TVALID = 1'b0;
    logic        ActDMA_TLAST = 1'b0;
    logic        ActDMA_TREADY;
    logic [8:0]  cfg_frame_words = 9'd4;
    logic        sync_vld;
    logic        sync_bank;
    logic [8:0]  sync_len;
    logic        sync_ack = 1'b0;
    logic [7:0]  rd_addr = '0;
    logic        rd_ce = 1'b0;
    logic [15:0] rd_q;
    logic        rel = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 ap_clk = ~ap_clk;

    act_pingpong_buffer #(
        .ACT_W  (8),
        .PACK   (2),
        .AWIDTH (8),
        .DEPTH  (16)
    ) dut (
        .ap_clk          (ap_clk),
        .ap_rst_n        (ap_rst_n),
        .ActDMA_TDATA    (ActDMA_TDATA),
        .ActDMA_TVALID   (ActDMA_TVALID),
        .ActDMA_TLAST    (ActDMA_TLAST),
        .ActDMA_TREADY   (ActDMA_TREADY),
        .cfg_frame_words (cfg_frame_words),
        .sync_vld        (sync_vld),
        .sync_bank       (sync_bank),
        .sync_len        (sync_len),
        .sync_ack        (sync_ack),
        .rd_addr         (rd_addr),
        .rd_ce           (rd_ce),
        .rd_q            (rd_q),
        .rel             (rel)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: frames, handover queue, PE ownership ----------------
    typedef struct packed {
        logic              bank;
        logic [8:0]        len;
        logic [15:0][15:0] w;
    } frame_t;

    frame_t     fullq[$];
    frame_t     rdf;
    frame_t     newf;
    logic [7:0] acts[$];
    bit         reading_m;
    int         flen_m;
    int         fidx;
    logic       exp_tready;
    logic       exp_vld;
    logic       exp_bank;
    logic [8:0] exp_len;
    logic [15:0] exp_rdq;

    always @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            fullq.delete();
            acts.delete();
            reading_m  = 0;
            flen_m     = 0;
            fidx       = 0;
            exp_tready = 1'b0;
            exp_vld    = 1'b0;
            exp_bank   = 1'b0;
            exp_len    = '0;
            exp_rdq    = '0;
        end else begin
            if (rd_ce && reading_m) exp_rdq = rdf.w[rd_addr[3:0]];
            if (ActDMA_TVALID && exp_tready) begin
                if (acts.size() == 0)
                    flen_m = (cfg_frame_words == 0 || cfg_frame_words > 16) ? 16 : int'(cfg_frame_words);
                acts.push_back(ActDMA_TDATA);
                if (ActDMA_TLAST || acts.size() == 2 * flen_m) begin
                    newf      = '0;
                    newf.bank = fidx[0];
                    newf.len  = 9'((acts.size() + 1) / 2);
                    for (int i = 0; i < acts.size(); i++) newf.w[i/2][(i%2)*8 +: 8] = acts[i];
                    fullq.push_back(newf);
                    fidx++;
                    acts.delete();
                end
            end
            if (sync_ack && exp_vld) begin
                rdf = fullq.pop_front();
                reading_m = 1;
            end else if (rel && reading_m) begin
                reading_m = 0;
            end
            exp_tready = (fullq.size() + (reading_m ? 1 : 0)) < 2;
            exp_vld    = !reading_m && (fullq.size() != 0);
            if (exp_vld) begin
                exp_bank = fullq[0].bank;
                exp_len  = fullq[0].len;
            end
        end
    end

    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            check("rst_tready", ActDMA_TREADY, 0);
            check("rst_vld", sync_vld, 0);
            check("rst_bank", sync_bank, 0);
            check("rst_len", sync_len, 0);
            check("rst_rdq", rd_q, 0);
        end else begin
            check("m_tready", ActDMA_TREADY, exp_tready);
            check("m_vld", sync_vld, exp_vld);
            if (exp_vld) begin
                check("m_bank", sync_bank, exp_bank);
                check("m_len", sync_len, exp_len);
            end
            check("m_rdq", rd_q, exp_rdq);
        end
    end

    // ---------------- stimulus helpers (all return at posedge+1) ----------------
    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        int guard = 0;
        ActDMA_TDATA  = d;
        ActDMA_TLAST  = last;
        ActDMA_TVALID = 1'b1;
        while (!ActDMA_TREADY && guard < 300) begin
            tick();
            guard++;
        end
        if (guard >= 300) check("tready_timeout", 0, 1);
        tick();
        ActDMA_TVALID = 1'b0;
        ActDMA_TLAST  = 1'b0;
    endtask

    task automatic frame(input logic [7:0] base, input int n, input int last_at);
        for (int i = 0; i < n; i++) send(8'(int'(base) + i), i == last_at);
    endtask

    task automatic ack();
        int guard = 0;
        while (!sync_vld && guard < 300) begin
            tick();
            guard++;
        end
        if (guard >= 300) check("vld_timeout", 0, 1);
        sync_ack = 1'b1;
        tick();
        sync_ack = 1'b0;
    endtask

    task automatic pulse_rel();
        rel = 1'b1;
        tick();
        rel = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [7:0] a, input logic [15:0] e);
        rd_ce   = 1'b1;
        rd_addr = a;
        tick();
        rd_ce   = 1'b0;
        check(nm, rd_q, e);
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0;
        tick();
        tick();
        ap_rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge ap_clk);
        #1;
        check("reset_tready", ActDMA_TREADY, 0);
        check("reset_vld", sync_vld, 0);
        check("reset_rdq", rd_q, 0);
        ap_rst_n = 1'b1;

        // 1: plain frame of four words into bank 0
        cfg_frame_words = 9'd4;
        frame(8'h01, 8, -1);
        check("t1_vld", sync_vld, 1);
        check("t1_bank", sync_bank, 0);
        check("t1_len", sync_len, 4);
        ack();
        rd("t1_w0", 8'd0, 16'h0201);
        rd("t1_w1", 8'd1, 16'h0403);
        rd("t1_w2", 8'd2, 16'h0605);
        rd("t1_w3", 8'd3, 16'h0807);
        pulse_rel();

        // 2: three back-to-back frames, PE slow to ack
        do_reset();
        frame(8'h11, 8, -1);
        frame(8'h21, 8, -1);
        check("t2_tready_low", ActDMA_TREADY, 0);
        check("t2_vld", sync_vld, 1);
        check("t2_bank0", sync_bank, 0);
        fork
            frame(8'h31, 8, -1);
            begin
                repeat (4) tick();
                check("t2_still_blocked", ActDMA_TREADY, 0);
                ack();
                rd("t2_a_w2", 8'd2, 16'h1615);
                pulse_rel();
                check("t2_tready_back", ActDMA_TREADY, 1);
                check("t2_vld_b", sync_vld, 1);
                check("t2_bank1", sync_bank, 1);
            end
        join
        check("t2_tready_full", ActDMA_TREADY, 0);
        ack();
        rd("t2_b_w0", 8'd0, 16'h2221);
        pulse_rel();
        check("t2_c_bank", sync_bank, 0);
        ack();
        rd("t2_c_w0", 8'd0, 16'h3231);
        rd("t2_c_w3", 8'd3, 16'h3837);
        pulse_rel();

        // 3: TLAST on the third beat leaves a zero-padded partial word
        do_reset();
        frame(8'h01, 3, 2);
        check("t3_vld", sync_vld, 1);
        check("t3_bank", sync_bank, 0);
        check("t3_len", sync_len, 2);
        check("t3_tready", ActDMA_TREADY, 1);
        frame(8'h41, 8, -1);
        ack();
        rd("t3_w0", 8'd0, 16'h0201);
        rd("t3_w1", 8'd1, 16'h0003);
        pulse_rel();
        check("t3_next_bank", sync_bank, 1);
        check("t3_next_len", sync_len, 4);
        ack();
        rd("t3_n_w0", 8'd0, 16'h4241);
        rd("t3_n_w3", 8'd3, 16'h4847);
        pulse_rel();

        // 4: cfg of 0 and of 100 both mean a full 16-word bank
        do_reset();
        cfg_frame_words = 9'd0;
        frame(8'h01, 31, -1);
        check("t4_open_at_31", sync_vld, 0);
        send(8'h20, 1'b0);
        check("t4_vld", sync_vld, 1);
        check("t4_len0", sync_len, 16);
        cfg_frame_words = 9'd100;
        frame(8'h81, 32, -1);
        check("t4_tready_low", ActDMA_TREADY, 0);
        ack();
        rd("t4_a_w15", 8'd15, 16'h201F);
        rd("t4_a_w0", 8'd0, 16'h0201);
        pulse_rel();
        check("t4_bank1", sync_bank, 1);
        check("t4_len100", sync_len, 16);
        ack();
        rd("t4_b_w15", 8'd15, 16'hA09F);
        pulse_rel();

        // 5: closing beat and rel in the same cycle
        do_reset();
        cfg_frame_words = 9'd2;
        frame(8'h51, 4, -1);
        ack();
        rd("t5_a_w1", 8'd1, 16'h5453);
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        send(8'h63, 1'b0);
        rel = 1'b1;
        send(8'h64, 1'b0);
        rel = 1'b0;
        check("t5_vld", sync_vld, 1);
        check("t5_bank", sync_bank, 1);
        check("t5_len", sync_len, 2);
        check("t5_tready", ActDMA_TREADY, 1);
        rd("t5_rd_idle", 8'd0, 16'h5453);
        ack();
        rd_ce   = 1'b1;
        rd_addr = 8'd1;
        check("t5_rd_before_edge", rd_q, 16'h5453);
        tick();
        rd_ce = 1'b0;
        check("t5_rd_latency", rd_q, 16'h6463);
        pulse_rel();

        // 6: asynchronous reset while one bank is read and the other is filling
        do_reset();
        cfg_frame_words = 9'd4;
        frame(8'h01, 8, -1);
        ack();
        rd("t6_pre", 8'd1, 16'h0403);
        send(8'h71, 1'b0);
        send(8'h72, 1'b0);
        send(8'h73, 1'b0);
        #2;
        ap_rst_n = 1'b0;
        #1;
        check("t6_async_tready", ActDMA_TREADY, 0);
        check("t6_async_vld", sync_vld, 0);
        check("t6_async_bank", sync_bank, 0);
        check("t6_async_len", sync_len, 0);
        check("t6_async_rdq", rd_q, 0);
        @(posedge ap_clk);
        #1;
        tick();
        ap_rst_n = 1'b1;
        frame(8'h91, 8, -1);
        check("t6_vld", sync_vld, 1);
        check("t6_bank", sync_bank, 0);
        check("t6_len", sync_len, 4);
        ack();
        rd("t6_w0", 8'd0, 16'h9291);
        rd("t6_w3", 8'd3, 16'h9897);
        pulse_rel();

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
